// File: rtl/cpu_ad48_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ad48_pkg
// Shared definitions for the ad48 core. It provides the opcode and ALU-subop
// encodings, the instruction field positions, and encoding helpers that
// loaders and benches use to assemble 48-bit instruction words.
// This file has no ports.
// ---------------------------------------------------------------------------
package cpu_ad48_pkg;

    localparam int XLEN = 48;

    // Instruction field positions
    localparam int OP_MSB    = 47;
    localparam int OP_LSB    = 44;
    localparam int U_BIT     = 43;
    localparam int R1_MSB    = 42;
    localparam int R1_LSB    = 40;
    localparam int R2_MSB    = 39;
    localparam int R2_LSB    = 37;
    localparam int DISP_MSB  = 32;
    localparam int SUBOP_MSB = 30;
    localparam int SUBOP_LSB = 27;
    localparam int IMM_MSB   = 26;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LD     = 4'h1,
        OP_ST     = 4'h2,
        OP_ALUI_A = 4'h3,
        OP_ALUI_D = 4'h4,
        OP_SYS    = 4'hF
    } opcode_e;

    // Subops 8..15 have no name: they pass the source through unchanged.
    typedef enum logic [3:0] {
        F_ADD = 4'h0,
        F_SUB = 4'h1,
        F_AND = 4'h2,
        F_OR  = 4'h3,
        F_XOR = 4'h4,
        F_SHL = 4'h5,
        F_SHR = 4'h6,
        F_MOV = 4'h7
    } subop_e;

    localparam logic [3:0] SYS_HALT = 4'hF;

    function automatic logic [47:0] to48(input longint v);
        return v[47:0];
    endfunction

    function automatic logic [32:0] pack_disp33(input longint d);
        return d[32:0];
    endfunction

    function automatic logic [26:0] pack_imm27(input longint i);
        return i[26:0];
    endfunction

    function automatic logic [3:0] pack_subop(input subop_e s);
        return s;
    endfunction

    function automatic logic [47:0] instr_ld(input logic [2:0] rd, input logic [2:0] ra,
                                             input logic u, input longint disp);
        return {OP_LD, u, rd, ra, 4'b0, pack_disp33(disp)};
    endfunction

    function automatic logic [47:0] instr_st(input logic [2:0] rs, input logic [2:0] ra,
                                             input logic u, input longint disp);
        return {OP_ST, u, rs, ra, 4'b0, pack_disp33(disp)};
    endfunction

    function automatic logic [47:0] instr_alui_a(input subop_e s, input logic u, input logic [2:0] rd,
                                                 input logic [2:0] rs, input longint imm);
        return {OP_ALUI_A, u, rd, rs, 6'b0, pack_subop(s), pack_imm27(imm)};
    endfunction

    function automatic logic [47:0] instr_alui_d(input subop_e s, input logic u, input logic [2:0] rd,
                                                 input logic [2:0] rs, input longint imm);
        return {OP_ALUI_D, u, rd, rs, 6'b0, pack_subop(s), pack_imm27(imm)};
    endfunction

    function automatic logic [47:0] instr_sys(input logic [3:0] code);
        return {OP_SYS, 1'b0, 3'b0, 3'b0, 33'b0, code};
    endfunction

endpackage

// File: rtl/cpu_ad48_mem.sv
// ---------------------------------------------------------------------------
// cpu_ad48_mem
// Word-addressed 48-bit memory. It has one synchronous write port and one
// asynchronous read port. The contents are never reset; a loader preloads the
// array `mem` through hierarchy.
//   clk    in   core clock
//   we     in   write enable, sampled on posedge
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index (combinational read)
//   rdata  out  read data
// ---------------------------------------------------------------------------
module cpu_ad48_mem #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [47:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [47:0]   rdata
);

    logic [47:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_ad48_regfile.sv
// ---------------------------------------------------------------------------
// cpu_ad48_regfile
// Eight 48-bit registers `regs[0:7]`. It has one asynchronous read port and
// one synchronous write port. Reset clears every register. When ZERO_R0 is
// set, register 0 always reads as zero and writes to it are dropped.
//   clk    in   core clock
//   rst    in   synchronous active-high reset (has priority over writes)
//   we     in   write enable
//   waddr  in   write register index
//   wdata  in   write data
//   raddr  in   read register index
//   rdata  out  read data
// ---------------------------------------------------------------------------
module cpu_ad48_regfile #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  waddr,
    input  logic [47:0] wdata,
    input  logic [2:0]  raddr,
    output logic [47:0] rdata
);

    logic [47:0] regs [0:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !(ZERO_R0 && (waddr == 3'd0))) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = (ZERO_R0 && (raddr == 3'd0)) ? 48'd0 : regs[raddr];

endmodule

// File: rtl/cpu_ad48.sv
// ---------------------------------------------------------------------------
// cpu_ad48
// Single-cycle 48-bit core with an address register file (A0 hard-zero) and a
// data register file. It executes LD/ST with optional base writeback,
// ALU-immediate on the A or D file, and SYS/HALT. Instruction and data
// memories are internal. Both are indexed by the low address bits, so
// IM_WORDS and DM_WORDS must be powers of two.
//   clk   in   core clock
//   rst   in   synchronous active-high reset
//   halt  out  sticky, high after HALT executes until rst
// ---------------------------------------------------------------------------
module cpu_ad48
    import cpu_ad48_pkg::*;
#(
    parameter int IM_WORDS = 128,
    parameter int DM_WORDS = 128
) (
    input  logic clk,
    input  logic rst,
    output logic halt
);

    localparam int IM_AW = $clog2(IM_WORDS);
    localparam int DM_AW = $clog2(DM_WORDS);

    logic [47:0] pc_q, pc_d;
    logic        halt_q, halt_d;

    logic [47:0] instr;
    logic [3:0]  op;
    logic        u;
    logic [2:0]  r1, r2;
    logic [3:0]  subop;
    logic [47:0] disp, imm, ea, alu_src, alu_res;

    logic [2:0]  a_raddr, d_raddr, a_waddr, d_waddr;
    logic [47:0] a_rdata, d_rdata, a_wdata, d_wdata;
    logic        a_we, d_we, dm_we;
    logic [47:0] dm_rdata;

    function automatic logic [47:0] alu(input logic [3:0] f, input logic [47:0] src,
                                        input logic [47:0] im);
        case (f)
            F_ADD:   return src + im;
            F_SUB:   return src - im;
            F_AND:   return src & im;
            F_OR:    return src | im;
            F_XOR:   return src ^ im;
            F_SHL:   return src << im[5:0];
            F_SHR:   return src >> im[5:0];
            F_MOV:   return im;
            default: return src;
        endcase
    endfunction

    cpu_ad48_mem #(.WORDS(IM_WORDS), .AW(IM_AW)) IMEM (
        .clk   (clk),
        .we    (1'b0),
        .waddr ({IM_AW{1'b0}}),
        .wdata (48'd0),
        .raddr (pc_q[IM_AW-1:0]),
        .rdata (instr)
    );

    cpu_ad48_mem #(.WORDS(DM_WORDS), .AW(DM_AW)) DMEM (
        .clk   (clk),
        .we    (dm_we),
        .waddr (ea[DM_AW-1:0]),
        .wdata (d_rdata),
        .raddr (ea[DM_AW-1:0]),
        .rdata (dm_rdata)
    );

    cpu_ad48_regfile #(.ZERO_R0(1'b1)) RF_A (
        .clk   (clk),
        .rst   (rst),
        .we    (a_we),
        .waddr (a_waddr),
        .wdata (a_wdata),
        .raddr (a_raddr),
        .rdata (a_rdata)
    );

    cpu_ad48_regfile #(.ZERO_R0(1'b0)) RF_D (
        .clk   (clk),
        .rst   (rst),
        .we    (d_we),
        .waddr (d_waddr),
        .wdata (d_wdata),
        .raddr (d_raddr),
        .rdata (d_rdata)
    );

    // Decode and operand selection
    always_comb begin
        op    = instr[OP_MSB:OP_LSB];
        u     = instr[U_BIT];
        r1    = instr[R1_MSB:R1_LSB];
        r2    = instr[R2_MSB:R2_LSB];
        subop = instr[SUBOP_MSB:SUBOP_LSB];
        disp  = {{15{instr[DISP_MSB]}}, instr[DISP_MSB:0]};
        imm   = u ? {{21{instr[IMM_MSB]}}, instr[IMM_MSB:0]} : {21'd0, instr[IMM_MSB:0]};
        // The A read port always carries the base or the ALUI_A source (both r2).
        // The D read port carries the store data (r1) or the ALUI_D source (r2).
        a_raddr = r2;
        d_raddr = (op == OP_ST) ? r1 : r2;
        ea      = a_rdata + disp;
        alu_src = (op == OP_ALUI_A) ? a_rdata : d_rdata;
        alu_res = alu(subop, alu_src, imm);
    end

    // Execute: write enables and next PC/halt. Nothing commits during reset or
    // once halted, which freezes PC, both register files and DMEM.
    always_comb begin
        pc_d    = pc_q;
        halt_d  = halt_q;
        a_we    = 1'b0;
        a_waddr = r2;
        a_wdata = ea;
        d_we    = 1'b0;
        d_waddr = r1;
        d_wdata = dm_rdata;
        dm_we   = 1'b0;
        if (!rst && !halt_q) begin
            pc_d = pc_q + 48'd1;
            case (op)
                OP_LD: begin
                    d_we = 1'b1;
                    a_we = u;
                end
                OP_ST: begin
                    dm_we = 1'b1;
                    a_we  = u;
                end
                OP_ALUI_A: begin
                    a_we    = 1'b1;
                    a_waddr = r1;
                    a_wdata = alu_res;
                end
                OP_ALUI_D: begin
                    d_we    = 1'b1;
                    d_wdata = alu_res;
                end
                OP_SYS: begin
                    if (instr[3:0] == SYS_HALT) begin
                        halt_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
        end
    end

    assign halt = halt_q;

    // The upper PC bits only matter as architectural state, and instr[36:33]
    // is reserved, so neither feeds any logic.
    logic unused_bits;
    assign unused_bits = ^{pc_q[47:IM_AW], instr[36:33]};

endmodule

// File: tb/tb_cpu_ad48.sv
// ---------------------------------------------------------------------------
// tb_cpu_ad48
// Directed program bench for cpu_ad48. A behavioural ISA model runs alongside
// the core, and the full architectural state is compared after every clock.
// Literal checks at fixed points pin the model as well.
// ---------------------------------------------------------------------------
module tb_cpu_ad48;

    logic clk;
    logic rst;
    logic halt;

    int checks = 0;
    int errors = 0;

    cpu_ad48 dut (
        .clk  (clk),
        .rst  (rst),
        .halt (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model state ----------------
    logic [47:0] prog [0:127];
    logic [47:0] m_a  [0:7];
    logic [47:0] m_d  [0:7];
    logic [47:0] m_dm [0:127];
    logic [47:0] m_pc;
    logic        m_halt;

    // ---------------- instruction encoders ----------------
    function automatic logic [47:0] enc(input int op, input bit u, input int r1, input int r2,
                                        input logic [36:0] rest);
        logic [3:0] o;
        logic [2:0] a;
        logic [2:0] b;
        o = op[3:0];
        a = r1[2:0];
        b = r2[2:0];
        return {o, u, a, b, rest};
    endfunction

    function automatic logic [47:0] mem_op(input int op, input bit u, input int r1, input int r2,
                                           input longint disp);
        logic [63:0] dv;
        dv = disp;
        return enc(op, u, r1, r2, {4'b0, dv[32:0]});
    endfunction

    function automatic logic [47:0] alui(input int op, input int subop, input bit u, input int rd,
                                         input int rs, input longint imm);
        logic [63:0] iv;
        logic [3:0]  s;
        iv = imm;
        s  = subop[3:0];
        return enc(op, u, rd, rs, {6'b0, s, iv[26:0]});
    endfunction

    function automatic logic [47:0] sys(input int code);
        logic [3:0] c;
        c = code[3:0];
        return enc(15, 1'b0, 0, 0, {33'b0, c});
    endfunction

    // ---------------- behavioural model ----------------
    task automatic model_step(input logic r);
        logic [47:0]        ins;
        int                 op, subop, r1, r2;
        bit                 u;
        logic signed [32:0] d33;
        logic signed [26:0] i27;
        longint             lv;
        logic [47:0]        ea, imm, src, res;
        if (r) begin
            m_pc   = 48'd0;
            m_halt = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_a[i] = 48'd0;
                m_d[i] = 48'd0;
            end
            return;
        end
        if (m_halt) return;
        ins   = prog[int'(m_pc % 48'd128)];
        op    = int'(ins >> 44) & 15;
        u     = ins[43];
        r1    = int'(ins >> 40) & 7;
        r2    = int'(ins >> 37) & 7;
        subop = int'(ins >> 27) & 15;
        d33   = ins[32:0];
        lv    = d33;
        ea    = m_a[r2] + lv[47:0];
        m_pc  = m_pc + 48'd1;
        if (op == 1) begin
            m_d[r1] = m_dm[int'(ea % 48'd128)];
            if (u && r2 != 0) m_a[r2] = ea;
        end else if (op == 2) begin
            m_dm[int'(ea % 48'd128)] = m_d[r1];
            if (u && r2 != 0) m_a[r2] = ea;
        end else if (op == 3 || op == 4) begin
            i27 = ins[26:0];
            lv  = i27;
            imm = u ? lv[47:0] : {21'd0, ins[26:0]};
            src = (op == 3) ? m_a[r2] : m_d[r2];
            case (subop)
                0:       res = src + imm;
                1:       res = src - imm;
                2:       res = src & imm;
                3:       res = src | imm;
                4:       res = src ^ imm;
                5:       res = src << int'(imm % 48'd64);
                6:       res = src >> int'(imm % 48'd64);
                7:       res = imm;
                default: res = src;
            endcase
            if (op == 3) begin
                if (r1 != 0) m_a[r1] = res;
            end else begin
                m_d[r1] = res;
            end
        end else if (op == 15) begin
            if ((ins & 48'hF) == 48'hF) m_halt = 1'b1;
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input logic [47:0] model_v, input logic [47:0] dut_v,
                       input logic [47:0] value);
        chk({name, " (model)"}, model_v, value);
        chk({name, " (dut)"}, dut_v, value);
    endtask

    task automatic check_state();
        int k;
        chk("pc", dut.pc_q, m_pc);
        chk("halt", {47'd0, halt}, {47'd0, m_halt});
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("A%0d", i), dut.RF_A.regs[i], m_a[i]);
            chk($sformatf("D%0d", i), dut.RF_D.regs[i], m_d[i]);
        end
        k = 0;
        for (int i = 127; i >= 0; i--) begin
            if (dut.DMEM.mem[i] !== m_dm[i]) k = i;
        end
        chk($sformatf("dmem[%0d]", k), dut.DMEM.mem[k], m_dm[k]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(rst);
        #1;
        check_state();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 128; i++) begin
            prog[i] = 48'd0;
            m_dm[i] = (i < 9) ? 48'(100 * (i + 1)) : 48'd0;
        end
        prog[0]  = mem_op(1, 0, 0, 0, 0);          // LD D0,[A0+0]
        prog[1]  = mem_op(1, 0, 1, 0, 1);          // LD D1,[A0+1]
        prog[2]  = alui(3, 0, 0, 1, 1, 2);         // A1 = A1 + 2
        prog[3]  = mem_op(1, 1, 3, 1, 2);          // LD u D3,[A1+2]
        prog[4]  = mem_op(1, 0, 4, 1, -1);         // LD D4,[A1-1]
        prog[5]  = alui(4, 7, 1, 5, 5, 12345);     // D5 = 12345
        prog[6]  = mem_op(2, 0, 5, 1, 0);          // ST D5,[A1+0]
        prog[7]  = mem_op(1, 0, 2, 1, 0);          // LD D2,[A1]
        prog[8]  = mem_op(2, 1, 5, 1, -2);         // ST u D5,[A1-2]
        prog[9]  = alui(3, 7, 0, 2, 0, 5);         // A2 = 5
        prog[10] = alui(4, 7, 0, 6, 0, 67890);     // D6 = 67890
        prog[11] = mem_op(2, 1, 6, 2, 3);          // ST u D6,[A2+3]
        prog[12] = mem_op(1, 1, 7, 2, -2);         // LD u D7,[A2-2]
        prog[13] = mem_op(1, 1, 4, 2, -1);         // LD u D4,[A2-1]
        prog[14] = mem_op(1, 1, 1, 0, 2);          // LD u D1,[A0+2]
        prog[15] = alui(4, 1, 0, 0, 0, 1);         // D0 = D0 - 1
        prog[16] = alui(4, 4, 0, 0, 0, 255);       // D0 = D0 ^ 0xFF
        prog[17] = alui(4, 7, 1, 3, 0, -1);        // D3 = sext(-1)
        prog[18] = alui(4, 6, 0, 3, 3, 40);        // D3 >>= 40
        prog[19] = alui(4, 5, 0, 3, 3, 8);         // D3 <<= 8
        prog[20] = alui(4, 2, 0, 3, 3, 'hF0F0);    // D3 &= 0xF0F0
        prog[21] = alui(4, 3, 0, 3, 3, 5);         // D3 |= 5
        prog[22] = alui(3, 0, 1, 3, 0, -1);        // A3 = A0 + (-1)
        prog[23] = alui(3, 9, 0, 4, 3, 0);         // A4 = A3 (pass-through subop)
        prog[24] = mem_op(2, 0, 0, 0, 20);         // ST D0,[A0+20]
        prog[25] = enc(5, 1'b1, 1, 1, 37'h1F);     // undefined opcode
        prog[26] = sys(3);                         // SYS nop
        prog[27] = sys(15);                        // HALT
        prog[28] = alui(4, 0, 0, 0, 0, 1);         // D0 += 1 (must not run)
        for (int i = 0; i < 128; i++) begin
            dut.IMEM.mem[i] <= prog[i];
            dut.DMEM.mem[i] <= m_dm[i];
        end

        cycle();
        cycle();
        lit("reset pc", m_pc, dut.pc_q, 48'd0);
        lit("reset D7", m_d[7], dut.RF_D.regs[7], 48'd0);
        rst = 1'b0;

        repeat (15) cycle();
        lit("D0", m_d[0], dut.RF_D.regs[0], 48'd100);
        lit("D1", m_d[1], dut.RF_D.regs[1], 48'd12345);
        lit("D2", m_d[2], dut.RF_D.regs[2], 48'd12345);
        lit("D3", m_d[3], dut.RF_D.regs[3], 48'd500);
        lit("D4", m_d[4], dut.RF_D.regs[4], 48'd600);
        lit("D7", m_d[7], dut.RF_D.regs[7], 48'd700);
        lit("A1", m_a[1], dut.RF_A.regs[1], 48'd2);
        lit("A2", m_a[2], dut.RF_A.regs[2], 48'd5);
        lit("MEM2", m_dm[2], dut.DMEM.mem[2], 48'd12345);
        lit("MEM4", m_dm[4], dut.DMEM.mem[4], 48'd12345);
        lit("MEM8", m_dm[8], dut.DMEM.mem[8], 48'd67890);

        repeat (8) cycle();
        lit("D0 alu", m_d[0], dut.RF_D.regs[0], 48'd156);
        lit("D3 alu", m_d[3], dut.RF_D.regs[3], 48'hF005);
        lit("A3 sext", m_a[3], dut.RF_A.regs[3], 48'hFFFF_FFFF_FFFF);

        repeat (5) cycle();
        lit("halt", {47'd0, m_halt}, {47'd0, halt}, 48'd1);
        lit("halt pc", m_pc, dut.pc_q, 48'd28);
        lit("MEM20", m_dm[20], dut.DMEM.mem[20], 48'd156);
        lit("A4", m_a[4], dut.RF_A.regs[4], 48'hFFFF_FFFF_FFFF);

        repeat (4) cycle();
        lit("frozen pc", m_pc, dut.pc_q, 48'd28);
        lit("frozen D0", m_d[0], dut.RF_D.regs[0], 48'd156);

        // Loader clears MEM[20] while halted so a write during reset is visible.
        dut.DMEM.mem[20] <= 48'd0;
        m_dm[20] = 48'd0;
        cycle();

        rst = 1'b1;
        cycle();
        cycle();
        lit("rst halt", {47'd0, m_halt}, {47'd0, halt}, 48'd0);
        lit("rst pc", m_pc, dut.pc_q, 48'd0);
        lit("rst D0", m_d[0], dut.RF_D.regs[0], 48'd0);
        rst = 1'b0;

        repeat (4) cycle();
        lit("re D0", m_d[0], dut.RF_D.regs[0], 48'd100);
        lit("re D1", m_d[1], dut.RF_D.regs[1], 48'd200);
        lit("re D3", m_d[3], dut.RF_D.regs[3], 48'd12345);
        lit("re A1", m_a[1], dut.RF_A.regs[1], 48'd4);

        // Reset lands on the edge that would execute the ST at IMEM[24].
        repeat (20) cycle();
        lit("pre-abort pc", m_pc, dut.pc_q, 48'd24);
        rst = 1'b1;
        cycle();
        lit("abort MEM20", m_dm[20], dut.DMEM.mem[20], 48'd0);
        rst = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
